sparc_mem_core: RTL and testbench

- Minimal SPARC-V8 integer core slice: a control FSM plus a datapath.
- Datapath contains the IR, a 32x32 register file, an adder ALU, MAR/MDR and a byte-addressed big-endian RAM.
- The core executes one externally supplied instruction at a time: register/immediate ADD, ST (store word) and LD (load word).
- Used as the integration vehicle for register-to-memory paths before fetch logic exists.

---
 rtl/sparc_mem_core.sv | 138 +++++++++++++
 tb/tb_sparc_mem_core.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/sparc_mem_core.sv
// rtl/sparc_mem_core.sv - SPARC-V8 integer slice: control FSM, register file, adder ALU, MAR/MDR, big-endian RAM.
// Executes one externally loaded instruction at a time: ADD, ST and LD.
module sparc_mem_core #(
  parameter int RAM_BYTES = 256,
  parameter int MEM_LAT   = 1
) (
  input  logic        Clk,
  input  logic        RESET,
  input  logic        IR_Enable,
  input  logic [31:0] IR_In,
  output logic [31:0] IR_Out,
  output logic [31:0] ALU_Out,
  output logic [31:0] PSR_out,
  output logic        MFC,
  output logic        busy,
  input  logic [4:0]  dbg_reg_sel,
  output logic [31:0] dbg_reg_out,
  input  logic [7:0]  dbg_mem_addr,
  output logic [7:0]  dbg_mem_out
);

  localparam int AW = $clog2(RAM_BYTES);
  localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MEM, S_MEM_DONE} state_t;

  state_t        r_state;
  logic [31:0]   r_ir;
  logic [31:0]   r_rf [32];
  logic [AW-1:0] r_mar;
  logic [31:0]   r_mdr;
  logic [7:0]    r_ram [RAM_BYTES];
  logic [LW-1:0] r_lat;
  logic          r_mfc;
  logic [31:0]   r_psr;

  logic [1:0]    w_op;
  logic [4:0]    w_rd;
  logic [5:0]    w_op3;
  logic [4:0]    w_rs1;
  logic          w_i;
  logic [31:0]   w_op2;
  logic [31:0]   w_sum;
  logic [AW-1:0] w_ea;
  logic          w_is_add;
  logic          w_is_st;
  logic          w_is_ld;
  logic [AW-1:0] w_a0;
  logic [AW-1:0] w_a1;
  logic [AW-1:0] w_a2;
  logic [AW-1:0] w_a3;

  assign w_op     = r_ir[31:30];
  assign w_rd     = r_ir[29:25];
  assign w_op3    = r_ir[24:19];
  assign w_rs1    = r_ir[18:14];
  assign w_i      = r_ir[13];
  assign w_op2    = w_i ? {{19{r_ir[12]}}, r_ir[12:0]} : r_rf[r_ir[4:0]];
  assign w_sum    = r_rf[w_rs1] + w_op2;
  // Word-aligned and reduced modulo RAM size by truncation.
  assign w_ea     = {w_sum[AW-1:2], 2'b00};
  assign w_is_add = (w_op == 2'b10) && (w_op3 == 6'b000000);
  assign w_is_st  = (w_op == 2'b11) && (w_op3 == 6'b000100);
  assign w_is_ld  = (w_op == 2'b11) && (w_op3 == 6'b000000);

  assign w_a0 = {r_mar[AW-1:2], 2'b00};
  assign w_a1 = {r_mar[AW-1:2], 2'b01};
  assign w_a2 = {r_mar[AW-1:2], 2'b10};
  assign w_a3 = {r_mar[AW-1:2], 2'b11};

  assign IR_Out      = r_ir;
  assign ALU_Out     = w_sum;
  assign PSR_out     = r_psr;
  assign MFC         = r_mfc;
  assign busy        = (r_state != S_IDLE);
  assign dbg_reg_out = r_rf[dbg_reg_sel];
  assign dbg_mem_out = r_ram[dbg_mem_addr[AW-1:0]];

  always_ff @(posedge Clk or negedge RESET) begin
    if (!RESET) begin
      r_state <= S_IDLE;
      r_ir    <= '0;
      r_mar   <= '0;
      r_mdr   <= '0;
      r_lat   <= '0;
      r_mfc   <= 1'b0;
      r_psr   <= 32'h0000_0080;
      for (int k = 0; k < 32; k++) r_rf[k] <= '0;
      for (int k = 0; k < RAM_BYTES; k++) r_ram[k] <= '0;
    end else begin
      r_mfc <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (IR_Enable) begin
            r_ir    <= IR_In;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_lat <= '0;
          if (w_is_add) begin
            if (w_rd != 5'd0) r_rf[w_rd] <= w_sum;
            r_state <= S_IDLE;
          end else if (w_is_st || w_is_ld) begin
            r_mar   <= w_ea;
            if (w_is_st) r_mdr <= r_rf[w_rd];
            r_state <= S_MEM;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_MEM: begin
          // Access happens on the MEM_LAT-th edge spent in this state.
          if (r_lat == LW'(MEM_LAT - 1)) begin
            if (w_is_st) begin
              r_ram[w_a0] <= r_mdr[31:24];
              r_ram[w_a1] <= r_mdr[23:16];
              r_ram[w_a2] <= r_mdr[15:8];
              r_ram[w_a3] <= r_mdr[7:0];
            end else begin
              r_mdr <= {r_ram[w_a0], r_ram[w_a1], r_ram[w_a2], r_ram[w_a3]};
            end
            r_mfc   <= 1'b1;
            r_state <= S_MEM_DONE;
          end else begin
            r_lat <= r_lat + 1'b1;
          end
        end
        S_MEM_DONE: begin
          if (w_is_ld && (w_rd != 5'd0)) r_rf[w_rd] <= r_mdr;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sparc_mem_core.sv
// tb/tb_sparc_mem_core.sv - directed and random instruction checks of sparc_mem_core against an ISA-level model.
module tb_sparc_mem_core;

  localparam int RB = 256;

  logic        Clk = 1'b0;
  logic        RESET = 1'b0;
  logic        IR_Enable = 1'b0;
  logic [31:0] IR_In = '0;
  logic [31:0] IR_Out;
  logic [31:0] ALU_Out;
  logic [31:0] PSR_out;
  logic        MFC;
  logic        busy;
  logic [4:0]  dbg_reg_sel = '0;
  logic [31:0] dbg_reg_out;
  logic [7:0]  dbg_mem_addr = '0;
  logic [7:0]  dbg_mem_out;

  sparc_mem_core #(.RAM_BYTES(RB), .MEM_LAT(1)) dut (
    .Clk(Clk), .RESET(RESET), .IR_Enable(IR_Enable), .IR_In(IR_In),
    .IR_Out(IR_Out), .ALU_Out(ALU_Out), .PSR_out(PSR_out), .MFC(MFC), .busy(busy),
    .dbg_reg_sel(dbg_reg_sel), .dbg_reg_out(dbg_reg_out),
    .dbg_mem_addr(dbg_mem_addr), .dbg_mem_out(dbg_mem_out)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_reg [32];
  logic [7:0]  m_ram [RB];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd_reg(input int idx, output logic [31:0] v);
    dbg_reg_sel = 5'(idx);
    #1;
    v = dbg_reg_out;
  endtask

  task automatic rd_mem(input int a, output logic [7:0] v);
    dbg_mem_addr = 8'(a);
    #1;
    v = dbg_mem_out;
  endtask

  task automatic model_reset;
    for (int i = 0; i < 32; i++) m_reg[i] = '0;
    for (int i = 0; i < RB; i++) m_ram[i] = '0;
  endtask

  task automatic check_regs(input string tag);
    logic [31:0] v;
    for (int i = 0; i < 32; i++) begin
      rd_reg(i, v);
      chk($sformatf("%s r%0d", tag, i), v, m_reg[i]);
    end
  endtask

  task automatic check_ram(input string tag);
    logic [7:0] v;
    int nbad;
    nbad = 0;
    for (int a = 0; a < RB; a++) begin
      rd_mem(a, v);
      if (v !== m_ram[a]) nbad++;
    end
    chk({tag, " ram bytes differing"}, nbad, 0);
  endtask

  // Issues one instruction, checks its timing and effects, then applies it to the model.
  task automatic run(input logic [31:0] instr, input bit poke);
    int kind, rd, rs1, ea, k, n_mfc, mfc_k, exp_edges;
    logic [31:0] op2, sum, word, v;
    logic [7:0] b;
    rd  = int'(instr[29:25]);
    rs1 = int'(instr[18:14]);
    op2 = instr[13] ? {{19{instr[12]}}, instr[12:0]} : m_reg[instr[4:0]];
    sum = m_reg[rs1] + op2;
    ea  = int'((sum & 32'hFFFF_FFFC) % RB);
    word = {m_ram[ea], m_ram[ea+1], m_ram[ea+2], m_ram[ea+3]};
    if (instr[31:30] == 2'b10 && instr[24:19] == 6'd0) kind = 1;
    else if (instr[31:30] == 2'b11 && instr[24:19] == 6'd4) kind = 2;
    else if (instr[31:30] == 2'b11 && instr[24:19] == 6'd0) kind = 3;
    else kind = 0;
    exp_edges = (kind >= 2) ? 4 : 2;
    @(negedge Clk);
    IR_In = instr;
    IR_Enable = 1'b1;
    @(posedge Clk);
    #1 IR_Enable = 1'b0;
    k = 1; n_mfc = 0; mfc_k = 0;
    while (1) begin
      @(negedge Clk);
      if (MFC) begin n_mfc++; mfc_k = k; end
      if (k == 1) begin
        chk("busy after load", busy, 1);
        chk("alu_out", ALU_Out, sum);
      end
      if (poke && k == 2) begin IR_In = ~instr; IR_Enable = 1'b1; end
      if (poke && k == 3) IR_Enable = 1'b0;
      if (kind == 1 && k == 2) begin
        rd_reg(rd, v);
        chk("add writeback", v, (rd == 0) ? 32'd0 : sum);
      end
      if (kind == 2 && k == 3) begin
        rd_mem(ea + 3, b);
        chk("st byte3 timing", b, m_reg[rd][7:0]);
      end
      if (kind == 3 && k == 4) begin
        rd_reg(rd, v);
        chk("ld writeback", v, (rd == 0) ? 32'd0 : word);
      end
      if (!busy || k >= 20) break;
      @(posedge Clk);
      k++;
    end
    chk("edges to idle", k, exp_edges);
    chk("mfc pulses", n_mfc, (kind >= 2) ? 1 : 0);
    if (kind >= 2) chk("mfc cycle", mfc_k, 3);
    chk("ir held", IR_Out, instr);
    if (kind == 1 && rd != 0) m_reg[rd] = sum;
    if (kind == 3 && rd != 0) m_reg[rd] = word;
    if (kind == 2) begin
      m_ram[ea]   = m_reg[rd][31:24];
      m_ram[ea+1] = m_reg[rd][23:16];
      m_ram[ea+2] = m_reg[rd][15:8];
      m_ram[ea+3] = m_reg[rd][7:0];
    end
  endtask

  initial begin
    logic [31:0] v;
    logic [7:0] b0, b1, b2, b3;
    logic [31:0] instr;
    int kind;

    model_reset();
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("reset busy", busy, 0);
    chk("reset mfc", MFC, 0);
    chk("reset psr", PSR_out, 32'h0000_0080);
    chk("reset ir", IR_Out, 0);
    check_regs("reset");
    check_ram("reset");
    @(negedge Clk);
    RESET = 1'b1;

    run(32'h82002003, 0);
    run(32'h84002006, 0);
    rd_reg(1, v); chk("r1 after add imm", v, 3);
    rd_reg(2, v); chk("r2 after add imm", v, 6);

    run(32'h84004002, 0);
    rd_reg(2, v); chk("r2 after add reg", v, 9);
    chk("alu_out held ir", ALU_Out, 12);

    run(32'hC4202020, 0);
    rd_mem(32, b0); rd_mem(33, b1); rd_mem(34, b2); rd_mem(35, b3);
    chk("st ram[32..35]", {b0, b1, b2, b3}, 32'h0000_0009);
    check_regs("after st");

    run(32'hC6002020, 0);
    rd_reg(3, v); chk("r3 after ld", v, 9);
    run({2'b10, 5'd4, 6'b000000, 5'd3, 1'b1, 13'h1FFF}, 0);
    rd_reg(4, v); chk("r4 neg imm", v, 8);

    run({2'b10, 5'd5, 6'b000000, 5'd0, 1'b1, 13'h120}, 0);
    run({2'b11, 5'd2, 6'b000100, 5'd5, 1'b1, 13'd2}, 0);
    rd_mem(8'h20, b0); rd_mem(8'h23, b3);
    chk("wrap ram[0x20]", b0, 0);
    chk("wrap ram[0x23]", b3, 9);

    run({2'b10, 5'd6, 6'b000001, 5'd1, 1'b1, 13'd5}, 0);
    check_regs("after illegal");
    check_ram("after illegal");

    run({2'b11, 5'd4, 6'b000100, 5'd0, 1'b1, 13'd40}, 1);
    rd_mem(43, b3); chk("poke st ram[43]", b3, 8);

    for (int n = 0; n < 48; n++) begin
      kind = int'($urandom_range(0, 4));
      instr = $urandom;
      instr[18:14] = 5'($urandom_range(0, 7));
      case (kind)
        0, 1: begin instr[31:30] = 2'b10; instr[24:19] = 6'b000000; end
        2:    begin instr[31:30] = 2'b11; instr[24:19] = 6'b000100; end
        3:    begin instr[31:30] = 2'b11; instr[24:19] = 6'b000000; end
        default: ;
      endcase
      run(instr, 0);
      if (n % 12 == 11) check_regs("random");
    end
    check_ram("random");

    run({2'b10, 5'd7, 6'b000000, 5'd0, 1'b1, 13'd77}, 0);
    @(negedge Clk);
    IR_In = {2'b11, 5'd7, 6'b000100, 5'd0, 1'b1, 13'd64};
    IR_Enable = 1'b1;
    @(posedge Clk);
    #1 IR_Enable = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    chk("busy before abort", busy, 1);
    RESET = 1'b0;
    #1;
    model_reset();
    chk("abort busy", busy, 0);
    chk("abort mfc", MFC, 0);
    chk("abort psr", PSR_out, 32'h0000_0080);
    chk("abort ir", IR_Out, 0);
    check_ram("abort");
    check_regs("abort");
    @(negedge Clk);
    RESET = 1'b1;
    run(32'h82002003, 0);
    rd_reg(1, v); chk("r1 after abort", v, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
